pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Consumes branch resolution from the EXE/MEM register (mem_branch, mem_bpc), load-use information from ID/EXE, and a ready handshake from data memory.
- Drives PC redirect, per-stage write enables and flushes, and a bubble into MEM/WB.
- Holds a memory-wait FSM with a timeout, a sticky error flag, and saturating performance counters.

Parameters:
- TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before the error state; legal range 2..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- clrn  in  1  synchronous, active-high reset (1 = clear).
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- exe_wreg  in  1  EXE instruction writes a register.
- exe_m2reg  in  1  EXE instruction is a load.
- exe_rn  in  5  destination register of the EXE instruction.
- mem_branch  in  1  taken branch resolved in MEM.
- mem_bpc  in  32  branch target in MEM.
- mem_req  in  1  MEM instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_we  out  1  PC write enable.
- pc_sel_branch  out  1  PC next = pc_target.
- pc_target  out  32  redirect address.
- if_id_we  out  1  IF/ID write enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_exe_we  out  1  ID/EXE write enable.
- id_exe_flush  out  1  clear ID/EXE to bubble.
- exe_mem_we  out  1  EXE/MEM write enable.
- exe_mem_flush  out  1  clear EXE/MEM control bits.
- mem_wb_bubble  out  1  load a bubble into MEM/WB.
- mem_err  out  1  sticky memory timeout flag.
- stall_cnt  out  CNT_W  cycles with pc_we=0.
- flush_cnt  out  CNT_W  taken-branch redirects.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Wait counter wcnt is 8 bits.
- clrn=1 at an edge: state=RUN, wcnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
- While clrn=1, outputs are forced combinationally to:
  - all *_we=0
  - all *_flush=1 and mem_wb_bubble=1
  - pc_sel_branch=0
- Default outputs (RUN, no event):
  - all *_we=1
  - flushes=0, mem_wb_bubble=0
  - pc_sel_branch=0
  - pc_target=mem_bpc at all times
- Freeze condition: a freeze is (pc_we, if_id_we, id_exe_we, exe_mem_we)=0 with mem_wb_bubble=1, in the same cycle.
  - RUN & mem_req & ~mem_ready: freeze, then go to MEM_WAIT with wcnt=1.
  - MEM_WAIT & ~mem_ready: freeze, wcnt+1.
  - MEM_WAIT & wcnt==TIMEOUT-1 & ~mem_ready: next state ERROR, mem_err=1.
  - MEM_WAIT & mem_ready: this cycle behaves exactly as RUN (branch/load-use evaluated); next state RUN, wcnt=0.
- mem_ready in RUN with mem_req: single-cycle access, no freeze.
- Branch: when not frozen and mem_branch=1:
  - pc_we=1, pc_sel_branch=1
  - if_id_flush, id_exe_flush, exe_mem_flush=1
  - flush_cnt+1
  - load-use check suppressed.
- While frozen, mem_branch is ignored; it is acted on in the release cycle.
- Load-use: when not frozen and mem_branch=0, a hazard exists if:
  - exe_m2reg & exe_wreg & exe_rn!=0, and
  - (id_use_rs & id_rs==exe_rn) | (id_use_rt & id_rt==exe_rn).
  - Response: pc_we=0, if_id_we=0, id_exe_flush=1; exe_mem_we=1.
  - Exactly one bubble, since the load advances to MEM.
- ERROR: permanent freeze; mem_err stays 1; all inputs ignored until clrn.
- stall_cnt increments on every non-reset cycle with pc_we=0, including ERROR.
- Both counters saturate at all-ones; no wrap.
- Reset mid-MEM_WAIT or mid-ERROR returns to RUN on the next edge with all state cleared.

Test Plan:
- Reset, then 5 idle cycles -> all we=1, flushes=0, stall_cnt=0, flush_cnt=0, mem_err=0.
- Load to r5 in EXE, ID reads rs=5 with id_use_rs=1 -> exactly 1 cycle of pc_we=0, id_exe_flush=1; stall_cnt=1. Same case with exe_rn=0 -> no stall.
- mem_branch=1, mem_bpc=0x0000_0040 -> same cycle pc_sel_branch=1, pc_target=0x40, three flushes=1; flush_cnt=1. Load-use hazard in that cycle is not stalled.
- mem_req=1 with mem_ready low for 3 cycles, then high; mem_branch=1 throughout -> 3 frozen cycles, then redirect in the 4th; stall_cnt=3, flush_cnt=1, state returns to RUN.
- mem_req=1, mem_ready stuck low, TIMEOUT=16 -> mem_err=1 after 16 frozen cycles and stays 1. Then clrn pulse -> mem_err=0, state RUN, counters 0.
- Force 2^CNT_W+3 stall cycles (CNT_W=4 build) -> stall_cnt holds 0xF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for a 5-stage pipeline. It takes branch
// resolution from MEM, load-use information from ID/EXE and the data memory
// ready handshake. From these it drives the PC redirect, the per-stage write
// enables and flushes, and the MEM/WB bubble. A small memory-wait FSM
// (RUN / MEM_WAIT / ERROR) has a timeout that sets a sticky error flag. Two
// saturating performance counters track stall cycles and branch redirects.
//
// Parameters
//   TIMEOUT  maximum consecutive frozen memory-wait cycles before ERROR (2..255)
//   CNT_W    width of the performance counters
//
// Ports
//   clk            pipeline clock, rising edge
//   clrn           synchronous active-high clear
//   id_rs/id_rt    source register fields of the instruction in ID
//   id_use_rs/rt   ID instruction actually reads rs / rt
//   exe_wreg       EXE instruction writes a register
//   exe_m2reg      EXE instruction is a load
//   exe_rn         destination register of the EXE instruction
//   mem_branch     taken branch resolved in MEM
//   mem_bpc        branch target in MEM
//   mem_req        MEM instruction accesses data memory
//   mem_ready      data memory completes the access this cycle
//   pc_we, pc_sel_branch, pc_target   PC update control
//   if_id_we/flush, id_exe_we/flush, exe_mem_we/flush   pipeline register control
//   mem_wb_bubble  load a bubble into MEM/WB
//   mem_err        sticky memory timeout flag
//   stall_cnt      saturating count of cycles with pc_we=0
//   flush_cnt      saturating count of taken-branch redirects
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic [4:0]       exe_rn,
  input  logic             mem_branch,
  input  logic [31:0]      mem_bpc,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             pc_sel_branch,
  output logic [31:0]      pc_target,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_exe_we,
  output logic             id_exe_flush,
  output logic             exe_mem_we,
  output logic             exe_mem_flush,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [7:0]       WCNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic [7:0]       wcnt_reg, wcnt_next;
  logic             mem_err_reg, mem_err_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;

  logic freeze;
  logic load_hit;
  logic take_branch;
  logic load_use_stall;

  // --------------------------------------------------------------------------
  // Event decode shared by next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    freeze = 1'b0;
    case (state_reg)
      ST_RUN:      freeze = mem_req & ~mem_ready;
      ST_MEM_WAIT: freeze = ~mem_ready;
      ST_ERROR:    freeze = 1'b1;
      default:     freeze = 1'b1;
    endcase
  end

  // A load to r0 never produces a value, so it can never create a hazard.
  assign load_hit = exe_m2reg & exe_wreg & (exe_rn != 5'd0) &
                    ((id_use_rs & (id_rs == exe_rn)) |
                     (id_use_rt & (id_rt == exe_rn)));

  // A branch squashes the younger instructions, so the load-use check is
  // meaningless in that cycle.
  assign take_branch    = ~freeze & mem_branch;
  assign load_use_stall = ~freeze & ~mem_branch & load_hit;

  // --------------------------------------------------------------------------
  // State register (includes counters and sticky flag)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clrn) begin
      state_reg     <= ST_RUN;
      wcnt_reg      <= 8'd0;
      mem_err_reg   <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wcnt_reg      <= wcnt_next;
      mem_err_reg   <= mem_err_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    wcnt_next    = wcnt_reg;
    mem_err_next = mem_err_reg;

    case (state_reg)
      ST_RUN: begin
        if (freeze) begin
          state_next = ST_MEM_WAIT;
          wcnt_next  = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_next = ST_RUN;
          wcnt_next  = 8'd0;
        end else if (wcnt_reg == WCNT_LAST) begin
          // The RUN cycle that entered the wait counts as frozen cycle 1,
          // so this is frozen cycle TIMEOUT.
          state_next   = ST_ERROR;
          mem_err_next = 1'b1;
        end else begin
          wcnt_next = wcnt_reg + 8'd1;
        end
      end
      ST_ERROR: begin
        state_next   = ST_ERROR;
        mem_err_next = 1'b1;
      end
      default: begin
        state_next = ST_ERROR;
        mem_err_next = 1'b1;
      end
    endcase

    // The counters use the internal pc_we. In reset cycles the register
    // clear takes priority, so forced reset outputs are never counted.
    stall_cnt_next = stall_cnt_reg;
    if (!pc_we && (stall_cnt_reg != CNT_MAX))
      stall_cnt_next = stall_cnt_reg + 1'b1;

    flush_cnt_next = flush_cnt_reg;
    if (take_branch && (flush_cnt_reg != CNT_MAX))
      flush_cnt_next = flush_cnt_reg + 1'b1;
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_exe_we     = 1'b1;
    exe_mem_we    = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    mem_wb_bubble = 1'b0;
    pc_sel_branch = 1'b0;

    if (clrn) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_exe_we     = 1'b0;
      exe_mem_we    = 1'b0;
      if_id_flush   = 1'b1;
      id_exe_flush  = 1'b1;
      exe_mem_flush = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (freeze) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_exe_we     = 1'b0;
      exe_mem_we    = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (take_branch) begin
      pc_sel_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_exe_flush  = 1'b1;
      exe_mem_flush = 1'b1;
    end else if (load_use_stall) begin
      // Hold PC and IF/ID and insert one bubble into ID/EXE. The load still
      // moves into MEM, so the hazard is gone on the next cycle.
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_exe_flush = 1'b1;
    end
  end

  assign pc_target = mem_bpc;
  assign mem_err   = mem_err_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed-vector bench for pipe_hazard_ctrl. The main instance uses the
// default parameters. A second instance (CNT_W=4, TIMEOUT=2) shares the same
// inputs and exercises counter saturation and the minimum timeout.
// Control outputs are compared as one packed 9-bit word:
//   {pc_we, if_id_we, id_exe_we, exe_mem_we,
//    if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_bubble, pc_sel_branch}
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam logic [8:0] C_IDLE = 9'b1111_0000_0;
  localparam logic [8:0] C_RST  = 9'b0000_1111_0;
  localparam logic [8:0] C_FRZ  = 9'b0000_0001_0;
  localparam logic [8:0] C_BR   = 9'b1111_1110_1;
  localparam logic [8:0] C_LU   = 9'b0011_0100_0;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  id_rs, id_rt, exe_rn;
  logic        id_use_rs, id_use_rt, exe_wreg, exe_m2reg;
  logic        mem_branch, mem_req, mem_ready;
  logic [31:0] mem_bpc;

  logic        pc_we, pc_sel_branch, if_id_we, if_id_flush, id_exe_we;
  logic        id_exe_flush, exe_mem_we, exe_mem_flush, mem_wb_bubble, mem_err;
  logic [31:0] pc_target;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_we, s_pc_sel_branch, s_if_id_we, s_if_id_flush, s_id_exe_we;
  logic        s_id_exe_flush, s_exe_mem_we, s_exe_mem_flush, s_mem_wb_bubble;
  logic        s_mem_err;
  logic [31:0] s_pc_target;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .clrn(clrn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_rn(exe_rn),
    .mem_branch(mem_branch), .mem_bpc(mem_bpc),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_sel_branch(pc_sel_branch), .pc_target(pc_target),
    .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_exe_we(id_exe_we), .id_exe_flush(id_exe_flush),
    .exe_mem_we(exe_mem_we), .exe_mem_flush(exe_mem_flush),
    .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.TIMEOUT(2), .CNT_W(4)) dut_small (
    .clk(clk), .clrn(clrn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_rn(exe_rn),
    .mem_branch(mem_branch), .mem_bpc(mem_bpc),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(s_pc_we), .pc_sel_branch(s_pc_sel_branch), .pc_target(s_pc_target),
    .if_id_we(s_if_id_we), .if_id_flush(s_if_id_flush),
    .id_exe_we(s_id_exe_we), .id_exe_flush(s_id_exe_flush),
    .exe_mem_we(s_exe_mem_we), .exe_mem_flush(s_exe_mem_flush),
    .mem_wb_bubble(s_mem_wb_bubble), .mem_err(s_mem_err),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  wire [8:0] ctrl = {pc_we, if_id_we, id_exe_we, exe_mem_we,
                     if_id_flush, id_exe_flush, exe_mem_flush,
                     mem_wb_bubble, pc_sel_branch};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %-14s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %-14s val=0x%08h t=%0t", tag, got, $time);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    exe_wreg = 1'b0; exe_m2reg = 1'b0; exe_rn = 5'd0;
    mem_branch = 1'b0; mem_bpc = 32'h0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rn);
    exe_wreg = 1'b1; exe_m2reg = 1'b1; exe_rn = rn;
  endtask

  initial begin
    idle_inputs();
    clrn = 1'b1;
    #2;
    // ---------------- reset ----------------
    chk("rst_ctrl", 32'(ctrl), 32'(C_RST));
    tick(); tick();
    clrn = 1'b0;
    #1;
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("idle_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("idle_stall", 32'(stall_cnt), 32'd0);
    chk("idle_flush", 32'(flush_cnt), 32'd0);

    // ---------------- load-use via rs ----------------
    set_load(5'd5); id_rs = 5'd5; id_use_rs = 1'b1;
    #1;
    chk("lu_rs_ctrl", 32'(ctrl), 32'(C_LU));
    tick();
    exe_m2reg = 1'b0; exe_wreg = 1'b0;  // load moved on to MEM
    #1;
    chk("lu_rs_after", 32'(ctrl), 32'(C_IDLE));
    chk("lu_rs_stall", 32'(stall_cnt), 32'd1);

    // load to r0 is never a hazard
    set_load(5'd0); id_rs = 5'd0; id_use_rs = 1'b1;
    #1;
    chk("lu_r0_ctrl", 32'(ctrl), 32'(C_IDLE));
    tick();
    chk("lu_r0_stall", 32'(stall_cnt), 32'd1);

    // load-use via rt; rs path disabled
    idle_inputs();
    set_load(5'd7); id_rt = 5'd7; id_use_rt = 1'b1; id_rs = 5'd7;
    #1;
    chk("lu_rt_ctrl", 32'(ctrl), 32'(C_LU));
    tick();
    chk("lu_rt_stall", 32'(stall_cnt), 32'd2);
    // matching field that is not read does not stall
    id_use_rt = 1'b0;
    #1;
    chk("lu_nouse", 32'(ctrl), 32'(C_IDLE));
    // non-load writer does not stall
    id_use_rt = 1'b1; exe_m2reg = 1'b0;
    #1;
    chk("lu_noload", 32'(ctrl), 32'(C_IDLE));
    tick();

    // ---------------- branch with simultaneous load-use ----------------
    idle_inputs();
    set_load(5'd3); id_rs = 5'd3; id_use_rs = 1'b1;
    mem_branch = 1'b1; mem_bpc = 32'h0000_0040;
    #1;
    chk("br_ctrl", 32'(ctrl), 32'(C_BR));
    chk("br_target", pc_target, 32'h0000_0040);
    tick();
    chk("br_flush", 32'(flush_cnt), 32'd1);
    chk("br_stall", 32'(stall_cnt), 32'd2);

    // ---------------- single-cycle memory access ----------------
    idle_inputs();
    mem_req = 1'b1; mem_ready = 1'b1;
    #1;
    chk("mem1_ctrl", 32'(ctrl), 32'(C_IDLE));
    tick();

    // ---------------- 3-cycle wait with pending branch ----------------
    mem_req = 1'b0; mem_ready = 1'b0;
    tick();  // let the small instance settle in RUN too
    mem_req = 1'b1; mem_ready = 1'b0; mem_branch = 1'b1; mem_bpc = 32'h0000_0080;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_frz", 32'(ctrl), 32'(C_FRZ));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("wait_rel", 32'(ctrl), 32'(C_BR));
    chk("wait_tgt", pc_target, 32'h0000_0080);
    tick();
    chk("wait_stall", 32'(stall_cnt), 32'd5);
    chk("wait_flush", 32'(flush_cnt), 32'd2);
    idle_inputs();
    #1;
    chk("wait_run", 32'(ctrl), 32'(C_IDLE));

    // ---------------- timeout to ERROR ----------------
    // Start from a freshly cleared state for both instances.
    clrn = 1'b1; tick(); clrn = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_err_low", 32'(mem_err), 32'd0);
      chk("to_small_err", 32'(s_mem_err), (i >= 2) ? 32'd1 : 32'd0);
      tick();
    end
    chk("to_err_set", 32'(mem_err), 32'd1);
    chk("to_stall", 32'(stall_cnt), 32'd16);
    // ERROR ignores ready and branch
    mem_ready = 1'b1; mem_req = 1'b0; mem_branch = 1'b1;
    #1;
    chk("err_ctrl", 32'(ctrl), 32'(C_FRZ));
    tick();
    chk("err_sticky", 32'(mem_err), 32'd1);
    chk("err_stall", 32'(stall_cnt), 32'd17);
    chk("err_flush", 32'(flush_cnt), 32'd0);
    clrn = 1'b1;
    #1;
    chk("err_rstctrl", 32'(ctrl), 32'(C_RST));
    tick();
    clrn = 1'b0;
    idle_inputs();
    #1;
    chk("clr_err", 32'(mem_err), 32'd0);
    chk("clr_stall", 32'(stall_cnt), 32'd0);
    chk("clr_ctrl", 32'(ctrl), 32'(C_IDLE));

    // ---------------- reset mid-MEM_WAIT ----------------
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();  // now waiting
    clrn = 1'b1;
    tick();
    clrn = 1'b0;
    idle_inputs();
    #1;
    chk("rstwait_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("rstwait_stall", 32'(stall_cnt), 32'd0);

    // ---------------- counter saturation (CNT_W=4 instance) ----------------
    set_load(5'd9); id_rs = 5'd9; id_use_rs = 1'b1;
    for (int i = 0; i < 19; i++) tick();
    chk("sat_stall_s", 32'(s_stall_cnt), 32'h0000_000F);
    chk("sat_stall_m", 32'(stall_cnt), 32'd19);
    idle_inputs();
    mem_branch = 1'b1; mem_bpc = 32'h0000_0100;
    for (int i = 0; i < 19; i++) tick();
    chk("sat_flush_s", 32'(s_flush_cnt), 32'h0000_000F);
    chk("sat_flush_m", 32'(flush_cnt), 32'd19);
    chk("sat_hold_s", 32'(s_stall_cnt), 32'h0000_000F);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
